// File: rtl/x86_pkg.sv
// Shared x86 constants and encoder FSM state, common to the ADD encoder and the decoder.
package x86_pkg;

   localparam logic [1:0] DATA_SIZE_8  = 2'b00;
   localparam logic [1:0] DATA_SIZE_16 = 2'b01;
   localparam logic [1:0] DATA_SIZE_32 = 2'b10;

   localparam logic DIR_L2R = 1'b0;
   localparam logic DIR_R2L = 1'b1;

   localparam logic [7:0] ADD_RM_R   = 8'h00;
   localparam logic [7:0] GRP1_IMM8  = 8'h80;
   localparam logic [7:0] GRP1_IMM   = 8'h81;
   localparam logic [7:0] GRP1_SX8   = 8'h83;
   localparam logic [7:0] PFX_OPSIZE = 8'h66;
   localparam logic [7:0] PAD_NOP    = 8'h90;

   localparam int MAX_INSTR_BYTES = 11;

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_DRAIN,
      ST_PAD
   } enc_state_e;

endpackage

// File: rtl/x86_instr_pack.sv
// Combinational ADD encoder: structured fields in, little-endian byte vector and length out.
module x86_instr_pack
   import x86_pkg::*;
(
   input  logic [1:0]                     i_opsize,
   input  logic                           i_dir,
   input  logic                           i_imm,
   input  logic                           i_imm_sx8,
   input  logic [1:0]                     i_mod,
   input  logic [2:0]                     i_reg,
   input  logic [2:0]                     i_rm,
   input  logic [1:0]                     i_scale,
   input  logic [2:0]                     i_index,
   input  logic [2:0]                     i_base,
   input  logic [31:0]                    i_disp,
   input  logic [31:0]                    i_imm_val,
   output logic [8*MAX_INSTR_BYTES-1:0]   o_bytes,
   output logic [3:0]                     o_len
);

   logic       wide;
   logic       has_sib;
   logic [2:0] disp_len;
   logic [2:0] imm_len;
   logic [3:0] n;

   assign wide    = (i_opsize != DATA_SIZE_8);
   assign has_sib = (i_mod != 2'b11) && (i_rm == 3'b100);

   always_comb begin
      disp_len = 3'd0;
      if (i_mod == 2'b01)
         disp_len = 3'd1;
      else if (i_mod == 2'b10)
         disp_len = 3'd4;
      else if (i_mod == 2'b00 && (i_rm == 3'b101 || (i_rm == 3'b100 && i_base == 3'b101)))
         disp_len = 3'd4;

      imm_len = 3'd4;
      if (i_opsize == DATA_SIZE_8 || i_imm_sx8)
         imm_len = 3'd1;
      else if (i_opsize == DATA_SIZE_16)
         imm_len = 3'd2;
   end

   // NOTE: n is a running write pointer, so blocking assignments are required here;
   // every output gets a default at the top so no latch is inferred.
   always_comb begin
      o_bytes = '0;
      n       = 4'd0;
      if (i_opsize == DATA_SIZE_16) begin
         o_bytes[{n, 3'b000} +: 8] = PFX_OPSIZE;
         n = n + 4'd1;
      end
      if (!i_imm)
         o_bytes[{n, 3'b000} +: 8] = ADD_RM_R | {6'b000000, i_dir, wide};
      else if (!wide)
         o_bytes[{n, 3'b000} +: 8] = GRP1_IMM8;
      else if (i_imm_sx8)
         o_bytes[{n, 3'b000} +: 8] = GRP1_SX8;
      else
         o_bytes[{n, 3'b000} +: 8] = GRP1_IMM;
      n = n + 4'd1;
      o_bytes[{n, 3'b000} +: 8] = {i_mod, (i_imm ? 3'b000 : i_reg), i_rm};
      n = n + 4'd1;
      if (has_sib) begin
         o_bytes[{n, 3'b000} +: 8] = {i_scale, i_index, i_base};
         n = n + 4'd1;
      end
      for (int k = 0; k < 4; k++) begin
         if (k < int'(disp_len)) begin
            o_bytes[{n, 3'b000} +: 8] = i_disp[8*k +: 8];
            n = n + 4'd1;
         end
      end
      if (i_imm) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(imm_len)) begin
               o_bytes[{n, 3'b000} +: 8] = i_imm_val[8*k +: 8];
               n = n + 4'd1;
            end
         end
      end
      o_len = n;
   end

endmodule

// File: rtl/x86_add_encoder.sv
// ADD instruction encoder: stages encoded bytes in a buffer and streams them as 32-bit words,
// first byte in bits [7:0]; a flush emits the residue as a PAD_BYTE-filled final word.
module x86_add_encoder
   import x86_pkg::*;
#(
   parameter int         BUF_BYTES = 16,
   parameter logic [7:0] PAD_BYTE  = 8'h90
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_instr_valid,
   output logic        o_instr_ready,
   input  logic [1:0]  i_opsize,
   input  logic        i_dir,
   input  logic        i_imm,
   input  logic        i_imm_sx8,
   input  logic [1:0]  i_mod,
   input  logic [2:0]  i_reg,
   input  logic [2:0]  i_rm,
   input  logic [1:0]  i_scale,
   input  logic [2:0]  i_index,
   input  logic [2:0]  i_base,
   input  logic [31:0] i_disp,
   input  logic [31:0] i_imm_val,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_data,
   output logic        o_last,
   output logic        o_err
);

   localparam int CNT_W = $clog2(BUF_BYTES + 1);
   localparam int IDX_W = $clog2(BUF_BYTES);

   enc_state_e                  state_q, state_d;
   logic [BUF_BYTES-1:0][7:0]   buf_q, buf_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        flush_pend_q, flush_pend_d;

   logic [8*MAX_INSTR_BYTES-1:0] ins_bytes;
   logic [3:0]                   ins_len;
   logic                         ins_legal, append, pop, flush_any;
   logic [CNT_W-1:0]             cnt_app, cnt_pop;

   x86_instr_pack u_pack (
      .i_opsize  (i_opsize),
      .i_dir     (i_dir),
      .i_imm     (i_imm),
      .i_imm_sx8 (i_imm_sx8),
      .i_mod     (i_mod),
      .i_reg     (i_reg),
      .i_rm      (i_rm),
      .i_scale   (i_scale),
      .i_index   (i_index),
      .i_base    (i_base),
      .i_disp    (i_disp),
      .i_imm_val (i_imm_val),
      .o_bytes   (ins_bytes),
      .o_len     (ins_len)
   );

   assign ins_legal = (i_opsize != 2'b11);
   assign append    = i_instr_valid && o_instr_ready && ins_legal;
   assign pop       = o_valid && i_ready;
   assign flush_any = flush_pend_q || i_flush;
   assign cnt_app   = cnt_q + (append ? CNT_W'(ins_len) : '0);
   assign cnt_pop   = cnt_q - CNT_W'(4);

   // NOTE: the buffer is cleared in reset as well so an idle o_data never carries stale bytes.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_ACCEPT;
         buf_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ACCEPT:
            if (cnt_app >= CNT_W'(4))
               state_d = ST_DRAIN;
            else if (i_flush && cnt_app != '0)
               state_d = ST_PAD;
         ST_DRAIN:
            if (pop) begin
               if (cnt_pop >= CNT_W'(4))
                  state_d = ST_DRAIN;
               else if (flush_any && cnt_pop != '0)
                  state_d = ST_PAD;
               else
                  state_d = ST_ACCEPT;
            end
         ST_PAD:
            if (pop)
               state_d = ST_ACCEPT;
         default:
            state_d = ST_ACCEPT;
      endcase
   end

   always_comb begin
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      unique case (state_q)
         ST_ACCEPT: begin
            if (append) begin
               for (int k = 0; k < MAX_INSTR_BYTES; k++)
                  if (k < int'(ins_len))
                     buf_d[IDX_W'(int'(cnt_q) + k)] = ins_bytes[8*k +: 8];
               cnt_d = cnt_app;
            end
            flush_pend_d = i_flush && (cnt_app != '0);
         end
         ST_DRAIN: begin
            flush_pend_d = flush_any;
            if (pop) begin
               buf_d = buf_q >> 32;
               cnt_d = cnt_pop;
               if (cnt_pop == '0)
                  flush_pend_d = 1'b0;
            end
         end
         ST_PAD:
            if (pop) begin
               cnt_d        = '0;
               flush_pend_d = 1'b0;
            end
         default: ;
      endcase
   end

   always_comb begin
      o_instr_ready = !i_reset && (state_q == ST_ACCEPT) && !flush_pend_q;
      o_valid       = (state_q != ST_ACCEPT);
      o_last        = (state_q == ST_PAD);
      o_err         = i_instr_valid && o_instr_ready && !ins_legal;
      o_data        = '0;
      if (state_q == ST_DRAIN)
         o_data = buf_q[3:0];
      else if (state_q == ST_PAD)
         for (int k = 0; k < 4; k++)
            o_data[8*k +: 8] = (k < int'(cnt_q)) ? buf_q[k] : PAD_BYTE;
   end

endmodule

// File: doc/x86_add_encoder.md
# x86_add_encoder

Instruction encoder for the ADD family, the transmit-side counterpart of the x86 decoder. It accepts one structured ADD instruction per handshake and emits the corresponding little-endian IA-32 byte stream. The stream is packed into 32-bit words, first byte in bits [7:0], in exactly the format the decoder consumes on i_data. It sits between the test/assembly front end and the decoder's word input, and holds partial words across instruction boundaries.

## Interface
Parameters:
- BUF_BYTES, 16: staging buffer depth in bytes; must be ≥ 3 + max instruction length (11).
- PAD_BYTE, 8'h90: filler byte for flushed partial words.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_instr_valid  in  1  instruction fields valid
- o_instr_ready  out  1  encoder can accept an instruction this cycle
- i_opsize  in  2  00=8-bit, 01=16-bit, 10=32-bit, 11=illegal
- i_dir  in  1  register-form direction bit: 0 = reg→r/m, 1 = r/m→reg
- i_imm  in  1  immediate form (80/81/83 /0)
- i_imm_sx8  in  1  use sign-extended imm8 (opcode 83); ignored when opsize=8
- i_mod  in  2  ModRM.mod
- i_reg  in  3  ModRM.reg; forced to 000 when i_imm=1
- i_rm  in  3  ModRM.rm
- i_scale, i_index, i_base  in  2,3,3  SIB fields
- i_disp  in  32  displacement; low bytes used per length
- i_imm_val  in  32  immediate; low bytes used per length
- i_flush  in  1  pulse: drain residual bytes as a padded final word
- o_valid  out  1  o_data holds a word
- i_ready  in  1  downstream accepts word
- o_data  out  32  packed bytes
- o_last  out  1  word is a padded flush word
- o_err  out  1  one-cycle pulse: illegal opsize dropped

## Operation
Byte assembly order, all in one accept cycle:
- Prefix: 0x66 when opsize=16.
- Opcode:
  - register form: {6'b000000, i_dir, w}, where w = (opsize != 8).
  - immediate form: 0x80 when opsize=8; 0x83 when i_imm_sx8; 0x81 otherwise.
- ModRM: {mod, reg, rm}.
- SIB: present iff mod != 11 and rm = 100.
- Displacement:
  - 1 byte when mod=01.
  - 4 bytes when mod=10.
  - 4 bytes when mod=00 and rm=101.
  - 4 bytes when mod=00, rm=100 and base=101.
  - none otherwise.
- Immediate (i_imm only): 1 byte for opsize 8 or sx8; 2 bytes for opsize 16; 4 bytes for opsize 32.
- Length ranges 2..11 bytes.

Buffer and counter:
- byte buffer buf[BUF_BYTES], count cnt 0..16.
- A new instruction is appended at byte offset cnt, and cnt += len.

FSM:
- ACCEPT: cnt<4 and no flush pending. o_instr_ready=1.
  - valid instruction → append; go to DRAIN if the new cnt≥4.
  - illegal opsize → drop, pulse o_err, cnt unchanged.
  - i_flush → set flush_pend; if cnt=0 the flush is a no-op.
- DRAIN: cnt≥4. o_valid=1, o_data=buf[3:0].
  - on i_ready: shift down 4 bytes, cnt -= 4.
  - next state: DRAIN if cnt still ≥4; else PAD if flush_pend and cnt>0; else ACCEPT.
- PAD: o_valid=1, o_last=1. o_data = residual bytes in the low lanes, PAD_BYTE in the upper lanes.
  - on i_ready: cnt=0, clear flush_pend, go to ACCEPT.

Boundary rules:
- o_instr_ready is low in DRAIN and PAD and while flush_pend is set, so accept and pop never coincide.
- i_flush and i_instr_valid in the same cycle: the instruction is appended first, then the flush is pending.
- A flush arriving while in DRAIN is latched and honored after the drain.
- Buffer overflow is impossible: 3+11 ≤ 16.

## Timing
Reset values:
- cnt=0, buffer all-zero, flush_pend=0, state ACCEPT.
- o_valid=0, o_data=0, o_last=0, o_err=0.
- o_instr_ready=0 while i_reset=1; 1 in the first cycle after release.

Latency and handshake:
- Instruction accepted at edge N: its first word is valid after edge N (visible in cycle N+1), or the bytes stay resident if cnt<4.
- Throughput is one word per cycle while i_ready=1.
- o_data, o_valid and o_last are stable while o_valid=1 and i_ready=0.
- o_err is a single cycle, aligned with the dropped handshake.

Reset mid-stream discards all buffered bytes and any pending flush. No partial word is emitted.

## Structure
- Package x86_pkg holds:
  - DATA_SIZE_8/16/32 codes and DIR_L2R/R2L, shared with the decoder.
  - opcode constants ADD_RM_R=8'h00, GRP1_IMM8=8'h80, GRP1_IMM=8'h81, GRP1_SX8=8'h83.
  - PFX_OPSIZE=8'h66, PAD_NOP=8'h90.
  - the FSM state enum.
- Sub-module x86_instr_pack: combinational. Inputs are the instruction fields; outputs are an 88-bit byte vector and a 4-bit length.
- The top level holds the buffer, the counter and the FSM.

## Test plan
- add %eax,%ecx (opsize=32, dir=0, mod=11, reg=000, rm=001), then i_flush → bytes 01 C1; single word 0x9090C101 with o_last=1.
- Imm8 instruction (opsize=8, i_imm, mod=11, rm=011, imm=05) followed by the register-form instruction above → word 0x0105C380; residual C1 (cnt=1).
- 16-bit immediate (opsize=16, i_imm, mod=11, rm=000, imm=0x1234) → word 0x34C08166; residual 12.
- Register form, mod=00 reg=010 rm=100, SIB scale=10 index=110 base=101, disp=0x11223344 → word 0x44B51401; flush → 0x90112233.
- 11-byte instruction (81 84 B5, disp 0x11223344, imm 0xAABBCCDD) with i_ready held low for 5 cycles:
  - o_data holds 0x44B58481 and o_instr_ready stays 0 throughout.
  - then 0xDD112233 is emitted; cnt=3 (CC BB AA).
- opsize=11 → o_err pulse, no bytes appended. Assert i_reset while cnt=3 with flush pending → o_valid=0, o_instr_ready=1 after release, no word emitted.
